// File: rtl/frame_scan_writer.sv
// frame_scan_writer
//
// Walks a SCREEN_W x SCREEN_H frame in row-major order, presents each
// coordinate to a pixel renderer and writes the renderer's color to a VGA
// adapter once the color arrives LATENCY clocks later.
//
// A scan starts on a rising edge of frameClk seen while idle. Each coordinate
// is issued exactly once with no gaps. The coordinate travels through a
// LATENCY-deep shift pipeline so that it lines up with its color. It is then
// registered into the VGA outputs together with a one-cycle plot strobe.
//
// Optional feature macro: FRAME_SCAN_QUEUE_EN
//   defined   : a frame request arriving while busy is remembered (one deep).
//               The queued scan starts right after the current one finishes.
//               The sticky overrun flag is raised and is only cleared by reset.
//   undefined : requests while busy are dropped and overrun is tied low.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   resetn     in   synchronous active-low reset
//   frameClk   in   frame request level, rising edge starts a scan
//   color[2:0] in   renderer color for the x/y issued LATENCY clocks earlier
//   x[7:0]     out  column presented to the renderer
//   y[7:0]     out  row presented to the renderer
//   vgaX[7:0]  out  column written to the VGA adapter
//   vgaY[7:0]  out  row written to the VGA adapter
//   vgaColor   out  color written to the VGA adapter
//   plot       out  VGA write strobe, one pixel per high cycle
//   busy       out  high from the first issue through the frameDone cycle
//   frameDone  out  one-cycle pulse alongside the final pixel's plot
//   overrun    out  sticky request-while-busy flag (queue build only)

module frame_scan_writer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int LATENCY  = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frameClk,
    input  logic [2:0] color,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [7:0] vgaX,
    output logic [7:0] vgaY,
    output logic [2:0] vgaColor,
    output logic       plot,
    output logic       busy,
    output logic       frameDone,
    output logic       overrun
);

    localparam logic [7:0] LAST_X = 8'(SCREEN_W - 1);
    localparam logic [7:0] LAST_Y = 8'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } scanState_t;

    scanState_t         state;
    logic               frameClkPrev;
    logic               frameEdge;
    logic               startReq;
    logic               issueValid;
    logic               tailValid;
    logic               tailLast;
    logic [LATENCY-1:0] pipeValid;
    logic [7:0]         pipeX [LATENCY];
    logic [7:0]         pipeY [LATENCY];

    // The previous-sample register comes out of reset at 1, so a frameClk
    // that is already high when reset releases is not mistaken for an edge.
    assign frameEdge  = frameClk & ~frameClkPrev;
    assign issueValid = (state == SCAN);
    assign tailValid  = pipeValid[LATENCY-1];
    assign tailLast   = tailValid
                        && (pipeX[LATENCY-1] == LAST_X)
                        && (pipeY[LATENCY-1] == LAST_Y);

`ifdef FRAME_SCAN_QUEUE_EN
    logic pending;

    // A request seen in any non-idle state (including the DRAIN cycle that
    // is about to exit) is parked here. It is consumed by the idle state on
    // the following cycle, which launches the queued scan.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else if (frameEdge && (state != IDLE)) begin
            pending <= 1'b1;
            overrun <= 1'b1;
        end else if (state == IDLE) begin
            pending <= 1'b0;
        end
    end

    assign startReq = frameEdge | pending;
`else
    assign overrun  = 1'b0;
    assign startReq = frameEdge;
`endif

    // Scan control. SCAN issues one coordinate per clock in row-major order.
    // DRAIN waits for the last coordinate to leave the pipeline and be
    // plotted. x/y sit at zero whenever nothing is being issued, so the next
    // scan begins at (0,0) without an extra load cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            frameClkPrev <= 1'b1;
            x            <= 8'd0;
            y            <= 8'd0;
            busy         <= 1'b0;
        end else begin
            frameClkPrev <= frameClk;
            case (state)
                IDLE: begin
                    if (startReq) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (x == LAST_X) begin
                        x <= 8'd0;
                        if (y == LAST_Y) begin
                            y     <= 8'd0;
                            state <= DRAIN;
                        end else begin
                            y <= y + 8'd1;
                        end
                    end else begin
                        x <= x + 8'd1;
                    end
                end
                DRAIN: begin
                    if (frameDone) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    x     <= 8'd0;
                    y     <= 8'd0;
                end
            endcase
        end
    end

    // Coordinate delay line. Stage 0 captures what is being issued this
    // cycle; the last stage lines up with the renderer's color output.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pipeValid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipeX[i] <= 8'd0;
                pipeY[i] <= 8'd0;
            end
        end else begin
            pipeValid[0] <= issueValid;
            pipeX[0]     <= x;
            pipeY[0]     <= y;
            for (int i = 1; i < LATENCY; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeX[i]     <= pipeX[i-1];
                pipeY[i]     <= pipeY[i-1];
            end
        end
    end

    // VGA write stage. The coordinate and color only update on a valid tail
    // entry, so the adapter sees stable values between strobes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vgaX      <= 8'd0;
            vgaY      <= 8'd0;
            vgaColor  <= 3'd0;
            plot      <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            plot      <= tailValid;
            frameDone <= tailLast;
            if (tailValid) begin
                vgaX     <= pipeX[LATENCY-1];
                vgaY     <= pipeY[LATENCY-1];
                vgaColor <= color;
            end
        end
    end

endmodule
